// File: rtl/sprite_frame_commit_ctrl.sv
// Sprite configuration controller: bus-written shadow registers are copied
// atomically into the active set at the start of vertical blank on request.
module sprite_frame_commit_ctrl #(
    parameter int NUM_SPRITES = 8,
    parameter int X_W         = 11,
    parameter int Y_W         = 10,
    parameter int VACTIVE     = 480
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         chipselect,
    input  logic                         write,
    input  logic                         read,
    input  logic [8:0]                   address,
    input  logic [31:0]                  writedata,
    output logic [31:0]                  readdata,
    input  logic [10:0]                  hcount,
    input  logic [9:0]                   vcount,
    output logic [NUM_SPRITES*X_W-1:0]   sprite_x,
    output logic [NUM_SPRITES*Y_W-1:0]   sprite_y,
    output logic [NUM_SPRITES-1:0]       sprite_en,
    output logic                         commit_pulse,
    output logic                         irq
);

    localparam logic [8:0] ADDR_EN     = 9'h40;
    localparam logic [8:0] ADDR_CTRL   = 9'h41;
    localparam logic [8:0] ADDR_STATUS = 9'h42;
    localparam logic [8:0] ADDR_FRAME  = 9'h43;
    localparam logic [9:0] VBLANK_LINE = 10'(VACTIVE);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COMMIT
    } state_t;

    state_t state, state_next;

    logic [X_W-1:0]         shadow_x [NUM_SPRITES];
    logic [Y_W-1:0]         shadow_y [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] shadow_en;
    logic [X_W-1:0]         active_x [NUM_SPRITES];
    logic [Y_W-1:0]         active_y [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] active_en;

    logic        irq_en;
    logic        irq_pending;
    logic [15:0] frame_cnt;
    logic [31:0] read_value;

    logic bus_wr;
    logic bus_rd;
    logic vblank_start;
    logic commit_req;
    logic status_clear;
    logic unused_wdata;

    assign bus_wr       = chipselect & write;
    assign bus_rd       = chipselect & read;
    assign vblank_start = (vcount == VBLANK_LINE) && (hcount == '0);
    assign commit_req   = bus_wr && (address == ADDR_CTRL) && writedata[0];
    assign status_clear = bus_wr && (address == ADDR_STATUS) && writedata[1];
    assign unused_wdata = ^writedata;

    // NOTE: the register arrays carry a reset because the active copy drives
    // the compositor and must read as zero straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_x[i] <= '0;
                shadow_y[i] <= '0;
            end
            shadow_en <= '0;
        end else if (bus_wr) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (address == 9'(2*i))     shadow_x[i] <= writedata[X_W-1:0];
                if (address == 9'(2*i + 1)) shadow_y[i] <= writedata[Y_W-1:0];
            end
            if (address == ADDR_EN) shadow_en <= writedata[NUM_SPRITES-1:0];
        end
    end

    // Copy sees the pre-write shadow value when a bus write lands in COMMIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                active_x[i] <= '0;
                active_y[i] <= '0;
            end
            active_en <= '0;
        end else if (state == COMMIT) begin
            active_x  <= shadow_x;
            active_y  <= shadow_y;
            active_en <= shadow_en;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            irq_en      <= 1'b0;
            irq_pending <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state <= state_next;
            if (bus_wr && (address == ADDR_CTRL)) irq_en <= writedata[1];
            // Setting from a commit outranks a software clear in the same cycle.
            if ((state == COMMIT) && irq_en) irq_pending <= 1'b1;
            else if (status_clear)           irq_pending <= 1'b0;
            if (vblank_start) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // NOTE: every combinational output gets its default first so no latch
    // is inferred on paths the case statement does not cover.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (commit_req) state_next = ARMED;
            ARMED:   if (vblank_start) state_next = COMMIT;
            COMMIT:  state_next = commit_req ? ARMED : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        read_value = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (address == 9'(2*i))     read_value[X_W-1:0] = shadow_x[i];
            if (address == 9'(2*i + 1)) read_value[Y_W-1:0] = shadow_y[i];
        end
        case (address)
            ADDR_EN:     read_value[NUM_SPRITES-1:0] = shadow_en;
            ADDR_CTRL:   read_value[1] = irq_en;
            ADDR_STATUS: read_value[1:0] = {irq_pending, state == ARMED};
            ADDR_FRAME:  read_value[15:0] = frame_cnt;
            default:     ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       readdata <= '0;
        else if (bus_rd) readdata <= read_value;
    end

    always_comb begin
        sprite_x = '0;
        sprite_y = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            sprite_x[i*X_W +: X_W] = active_x[i];
            sprite_y[i*Y_W +: Y_W] = active_y[i];
        end
    end

    assign sprite_en    = active_en;
    assign commit_pulse = (state == COMMIT);
    assign irq          = irq_pending & irq_en;

endmodule

// File: doc/sprite_frame_commit_ctrl.md
Name: sprite_frame_commit_ctrl

Overview:
- Avalon-MM configuration controller for the sprite display pipeline.
- Software writes sprite positions and enables into shadow registers. A requested commit copies all shadow registers into the active registers atomically at the start of vertical blank, so sprites never tear mid-frame.
- Also provides a frame counter, commit status readback and a vblank/commit interrupt.
- Sits between the bus slave port and the pixel compositor, which consumes the active registers.

Parameters:
- NUM_SPRITES, 8, number of sprite slots; legal range 1..32.
- X_W, 11, sprite x coordinate width.
- Y_W, 10, sprite y coordinate width.
- VACTIVE, 480, first non-visible line; vblank starts here.

Ports:
- clk  in  1  system clock, same clock as the VGA counters.
- reset  in  1  asynchronous, active-high.
- chipselect  in  1  bus select.
- write  in  1  bus write strobe.
- read  in  1  bus read strobe.
- address  in  9  word address.
- writedata  in  32  write data.
- readdata  out  32  read data, registered.
- hcount  in  11  horizontal pixel counter from the VGA timing generator.
- vcount  in  10  vertical line counter from the VGA timing generator.
- sprite_x  out  NUM_SPRITES*X_W  active x positions; slot i at bits [i*X_W +: X_W].
- sprite_y  out  NUM_SPRITES*Y_W  active y positions; slot i at bits [i*Y_W +: Y_W].
- sprite_en  out  NUM_SPRITES  active enable mask.
- commit_pulse  out  1  one-cycle pulse in the cycle the active registers update.
- irq  out  1  level interrupt, equal to irq_pending & irq_en.

Behaviour:
- Reset values: all shadow and active x/y = 0; enables = 0; readdata = 0; frame_cnt = 0; irq_en = 0; irq_pending = 0; commit_pulse = 0; FSM = IDLE.

Address map:
- 2i: shadow x of slot i, writedata[X_W-1:0].
- 2i+1: shadow y of slot i, writedata[Y_W-1:0].
- 0x40: shadow enable mask, writedata[NUM_SPRITES-1:0].
- 0x41 CTRL: bit0 write-1 = commit request; bit1 = irq_en (R/W). Bit0 reads as 0.
- 0x42 STATUS: bit0 = commit pending (FSM == ARMED), bit1 = irq_pending. Writing 1 to bit1 clears irq_pending.
- 0x43: frame_cnt[15:0], read-only.
- Unmapped, or slot index >= NUM_SPRITES: writes ignored, reads return 0.

Bus timing:
- Writes take effect on the clock edge where chipselect & write are high.
- Reads: readdata updates on the edge after chipselect & read; fixed 1-cycle latency, no wait states.
- Reads of slot registers return shadow values. Unused upper readdata bits are 0.

vblank_start:
- Internal 1-cycle strobe, true when vcount == VACTIVE and hcount == 0. Fires once per frame.
- frame_cnt increments by 1 on each vblank_start and wraps 0xFFFF -> 0.

FSM:
- IDLE: commit request -> ARMED. vblank_start is ignored for commit purposes.
- ARMED: vblank_start -> COMMIT. Further commit requests have no effect.
- COMMIT: lasts exactly 1 cycle.
  - All shadow x, y and enable registers are copied to active on this edge; commit_pulse = 1.
  - irq_pending is set if irq_en = 1.
  - Next state: IDLE.
- Latency: active outputs change 2 edges after the vblank_start cycle (edge 1 enters COMMIT, edge 2 copies).

Boundary cases:
- Shadow write in the COMMIT cycle: the copy uses the pre-write shadow value; the new value waits for the next commit.
- Commit request in the COMMIT cycle: accepted; FSM goes to ARMED instead of IDLE, and commits at the next frame.
- Commit request coinciding with vblank_start while IDLE: goes to ARMED; commits at the following frame's vblank_start.
- irq set and status clear in the same cycle: set wins.
- Clearing irq_en masks irq but does not clear irq_pending.
- Reset asserted mid-ARMED or mid-COMMIT: all state returns to reset values immediately; no partial copy is visible after reset.
- Active registers change only in COMMIT (or reset).

Test Plan:
- Write x0=100, y0=50, en=0x01, no commit; run 2 frames -> sprite_x[10:0] = 0, sprite_en = 0; reading addr 0 returns 100 one cycle after read.
- Write x0=100, then commit request at vcount=200 -> STATUS bit0 = 1. At vcount=480/hcount=0 + 2 edges: sprite_x slot0 = 100, commit_pulse high for exactly 1 cycle, STATUS bit0 = 0.
- irq_en=1, commit -> irq=1 after COMMIT. Write STATUS=0x2 in the same cycle as a second COMMIT -> irq stays 1. A following separate clear -> irq=0.
- Write x1=300 in the exact COMMIT cycle -> active x1 keeps its old value. After the next commit -> x1 = 300.
- Run 65537 vblank_start strobes from reset -> frame_cnt reads 1 (wrap check).
- Assert reset while ARMED with shadow x0=77 -> after release: FSM IDLE, STATUS = 0, active x0 = 0, shadow x0 reads 0.
